// File: rtl/vga_vram_arbiter_pkg.sv
// Shared definitions for the VGA frame-buffer arbiter.
//  - default widths and starvation threshold
//  - CPU-port FSM state encoding (2-bit)
//  - read-result owner tags used to steer RAM read data
package vga_vram_arbiter_pkg;

  localparam int ADDR_W_DEF   = 15;  // 160x120 = 19200 words
  localparam int DATA_W_DEF   = 8;   // RRRGGGBB
  localparam int WAIT_MAX_DEF = 15;

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_WR   = 2'd1,
    CPU_RD1  = 2'd2,
    CPU_RD2  = 2'd3
  } cpu_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/vga_vram_arbiter_counter.sv
// Saturating wait counter for the CPU port.
// Ports:
//  CLK        in  clock
//  RESET      in  synchronous clear (active high)
//  ENABLE_IN  in  count one step this cycle
//  SATURATED  out counter is at COUNTER_MAX
//  TRIG_OUT   out pulses on the step that brings the counter to COUNTER_MAX
module vga_vram_arbiter_counter
  import vga_vram_arbiter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = WAIT_MAX_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE_IN,
  output logic SATURATED,
  output logic TRIG_OUT
);

  logic [COUNTER_WIDTH-1:0] count;

  assign SATURATED = (count == COUNTER_WIDTH'(COUNTER_MAX));
  // Fires on the same edge the count lands on MAX, so a consumer's sticky
  // flag rises together with saturation.
  assign TRIG_OUT  = ENABLE_IN && (count == COUNTER_WIDTH'(COUNTER_MAX - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (ENABLE_IN && !SATURATED) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Arbiter sharing one single-port frame-buffer RAM (1-cycle registered read)
// between VGA scan-out (absolute priority, fixed 3-cycle latency) and a CPU
// slave port served in free slots.
//
// Handshakes:
//  DISP_REQ is a 1-cycle pulse with DISP_ADDR; DISP_VALID/DISP_DATA follow
//  exactly 3 cycles later. CPU_REQ is held high with stable fields until the
//  1-cycle CPU_ACK pulse; CPU_REQ is ignored while a transfer is in flight and
//  during the ack cycle itself, so a held request is granted only once.
//
// Ports:
//  CLK, RESET                          clock, synchronous active-high reset
//  DISP_REQ/DISP_ADDR                  display read request
//  DISP_VALID/DISP_DATA                display read result
//  CPU_REQ/CPU_WE/CPU_ADDR/CPU_WDATA   CPU request
//  CPU_ACK/CPU_RDATA                   CPU completion / read data
//  STARVE                              sticky: CPU waited WAIT_MAX cycles
//  RAM_EN/RAM_WE/RAM_ADDR/RAM_WDATA    registered RAM command
//  RAM_RDATA                           RAM read data (one cycle after command)
//  CPU_STATE                           current CPU FSM state (debug)
module vga_vram_arbiter
  import vga_vram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DISP_REQ,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic              DISP_VALID,
  output logic [DATA_W-1:0] DISP_DATA,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_ACK,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              STARVE,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic [1:0]        CPU_STATE
);

  cpu_state_t state, state_nxt;
  logic       cpu_grant;
  logic       cpu_waiting;
  logic       wait_saturated;
  logic       wait_trig;

  // own_cmd tags the RAM command issued this cycle; own_data tags the
  // RAM_RDATA present this cycle. Display reads may slot in while a CPU read
  // is in flight, so the tag (not the FSM) decides where data goes.
  owner_t own_cmd, own_data;

  assign CPU_STATE = state;

  always_comb begin
    state_nxt   = state;
    cpu_grant   = 1'b0;
    cpu_waiting = 1'b0;
    case (state)
      CPU_IDLE: begin
        // CPU_ACK high means this is the ack cycle of a read: the request
        // still on the bus is the one just completed.
        if (CPU_REQ && !CPU_ACK) begin
          if (!DISP_REQ) begin
            cpu_grant = 1'b1;
            state_nxt = CPU_WE ? CPU_WR : CPU_RD1;
          end else begin
            cpu_waiting = 1'b1;
          end
        end
      end
      CPU_WR:  state_nxt = CPU_IDLE;
      CPU_RD1: state_nxt = CPU_RD2;
      CPU_RD2: state_nxt = CPU_IDLE;
      default: state_nxt = CPU_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= CPU_IDLE;
      RAM_EN     <= 1'b0;
      RAM_WE     <= 1'b0;
      RAM_ADDR   <= '0;
      RAM_WDATA  <= '0;
      own_cmd    <= OWN_NONE;
      own_data   <= OWN_NONE;
      DISP_VALID <= 1'b0;
      DISP_DATA  <= '0;
      CPU_ACK    <= 1'b0;
      CPU_RDATA  <= '0;
      STARVE     <= 1'b0;
    end else begin
      state <= state_nxt;

      // RAM command: display first; cpu_grant already excludes DISP_REQ.
      RAM_EN <= DISP_REQ || cpu_grant;
      RAM_WE <= cpu_grant && CPU_WE;
      if (DISP_REQ) begin
        RAM_ADDR <= DISP_ADDR;
      end else if (cpu_grant) begin
        RAM_ADDR <= CPU_ADDR;
        if (CPU_WE) RAM_WDATA <= CPU_WDATA;
      end

      if (DISP_REQ)                  own_cmd <= OWN_DISP;
      else if (cpu_grant && !CPU_WE) own_cmd <= OWN_CPU;
      else                           own_cmd <= OWN_NONE;
      own_data <= own_cmd;

      DISP_VALID <= (own_data == OWN_DISP);
      if (own_data == OWN_DISP) DISP_DATA <= RAM_RDATA;

      // Writes complete as soon as the command is issued.
      CPU_ACK <= (cpu_grant && CPU_WE) || (own_data == OWN_CPU);
      if (own_data == OWN_CPU) CPU_RDATA <= RAM_RDATA;

      if (wait_trig) STARVE <= 1'b1;
    end
  end

  vga_vram_arbiter_counter #(
    .COUNTER_WIDTH(4),
    .COUNTER_MAX  (WAIT_MAX)
  ) u_wait_cnt (
    .CLK       (CLK),
    .RESET     (RESET || cpu_grant),
    .ENABLE_IN (cpu_waiting && !wait_saturated),
    .SATURATED (wait_saturated),
    .TRIG_OUT  (wait_trig)
  );

endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;
  import vga_vram_arbiter_pkg::*;

  localparam int AW   = 15;
  localparam int DW   = 8;
  localparam int NCYC = 4096;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          DISP_REQ = 1'b0;
  logic [AW-1:0] DISP_ADDR = '0;
  logic          DISP_VALID;
  logic [DW-1:0] DISP_DATA;
  logic          CPU_REQ = 1'b0;
  logic          CPU_WE = 1'b0;
  logic [AW-1:0] CPU_ADDR = '0;
  logic [DW-1:0] CPU_WDATA = '0;
  logic          CPU_ACK;
  logic [DW-1:0] CPU_RDATA;
  logic          STARVE;
  logic          RAM_EN, RAM_WE;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_WDATA;
  logic [DW-1:0] RAM_RDATA = '0;
  logic [1:0]    CPU_STATE;

  always #5 CLK = ~CLK;

  vga_vram_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR),
    .DISP_VALID(DISP_VALID), .DISP_DATA(DISP_DATA),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA), .STARVE(STARVE),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_RDATA(RAM_RDATA), .CPU_STATE(CPU_STATE)
  );

  // ---------------- RAM environment ----------------
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
      else        RAM_RDATA     <= mem[RAM_ADDR];
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expectations are scheduled per output cycle; cycle n is the one that
  // follows posedge number n. A request sampled at edge n has its RAM command
  // in cycle n, display data in n+2, CPU write ack in n, CPU read ack in n+2.
  int            edge_n = -1;
  logic          ex_dv  [NCYC];
  logic [DW-1:0] ex_dd  [NCYC];
  logic          ex_ack [NCYC];
  logic          ex_rdv [NCYC];
  logic [DW-1:0] ex_rd  [NCYC];
  logic          m_en, m_we, m_starve, m_rst;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_wcnt, m_ready_at;

  always @(posedge CLK) begin
    edge_n++;
    if (RESET) begin
      for (int k = 0; k < 4; k++) begin
        ex_dv[edge_n+k]  = 1'b0;
        ex_ack[edge_n+k] = 1'b0;
        ex_rdv[edge_n+k] = 1'b0;
      end
      m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_starve = 1'b0; m_wcnt = 0; m_ready_at = edge_n + 1; m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      m_en  = 1'b0;
      m_we  = 1'b0;
      if (DISP_REQ) begin
        m_en = 1'b1;
        m_addr = DISP_ADDR;
        ex_dv[edge_n+2] = 1'b1;
        ex_dd[edge_n+2] = ref_mem[DISP_ADDR];
      end
      if (CPU_REQ && edge_n >= m_ready_at) begin
        if (!DISP_REQ) begin
          m_en = 1'b1;
          m_we = CPU_WE;
          m_addr = CPU_ADDR;
          m_wcnt = 0;
          if (CPU_WE) begin
            m_wdata = CPU_WDATA;
            ref_mem[CPU_ADDR] = CPU_WDATA;
            ex_ack[edge_n] = 1'b1;
            m_ready_at = edge_n + 2;
          end else begin
            ex_ack[edge_n+2] = 1'b1;
            ex_rdv[edge_n+2] = 1'b1;
            ex_rd[edge_n+2]  = ref_mem[CPU_ADDR];
            m_ready_at = edge_n + 4;
          end
        end else begin
          if (m_wcnt < 15) m_wcnt++;
          if (m_wcnt == 15) m_starve = 1'b1;
        end
      end
    end
  end

  // Single compare process, every cycle after the first edge.
  always @(negedge CLK) begin
    if (edge_n >= 0 && !done) begin
      check("disp_valid", DISP_VALID, ex_dv[edge_n]);
      check("cpu_ack",    CPU_ACK,    ex_ack[edge_n]);
      check("starve",     STARVE,     m_starve);
      check("ram_en",     RAM_EN,     m_en);
      check("ram_we",     RAM_WE,     m_we);
      check("ram_addr",   RAM_ADDR,   m_addr);
      check("ram_wdata",  RAM_WDATA,  m_wdata);
      if (ex_dv[edge_n])  check("disp_data", DISP_DATA, ex_dd[edge_n]);
      if (ex_rdv[edge_n]) check("cpu_rdata", CPU_RDATA, ex_rd[edge_n]);
      if (m_rst) begin
        check("rst_disp_data", DISP_DATA, 0);
        check("rst_cpu_rdata", CPU_RDATA, 0);
        check("rst_state",     CPU_STATE, 0);
      end
    end
  end

  // Event monitor for literal latency checks.
  int            dv_edge[$];
  logic [DW-1:0] dv_data[$];
  int            ack_cnt = 0;
  always @(negedge CLK) begin
    if (DISP_VALID) begin
      dv_edge.push_back(edge_n);
      dv_data.push_back(DISP_DATA);
    end
    if (CPU_ACK) ack_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d;
  endtask

  // Waits for CPU_ACK (counting negedges), drops the request in the ack
  // cycle. DISP_REQ is also dropped so callers can issue a single pulse.
  task automatic cpu_wait_ack(output int lat, output logic [DW-1:0] rd);
    lat = -1;
    rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      DISP_REQ = 1'b0;
      if (CPU_ACK) begin
        rd = CPU_RDATA;
        CPU_REQ = 1'b0;
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      CPU_REQ = 1'b0;
      check("cpu_ack_timeout", 32'd1, 32'd0);
    end
  endtask

  // ---------------- directed tests ----------------
  int            lat, k0;
  logic [DW-1:0] rd, exp_d;
  logic [AW-1:0] a;

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      ex_dv[i] = 1'b0; ex_dd[i] = '0; ex_ack[i] = 1'b0; ex_rdv[i] = 1'b0; ex_rd[i] = '0;
    end
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i) ^ 8'hA5;
      ref_mem[i] = DW'(i) ^ 8'hA5;
    end

    // 1: reset
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("t1_rst_ram_en", RAM_EN, 0);
    check("t1_rst_dv",     DISP_VALID, 0);
    check("t1_rst_ack",    CPU_ACK, 0);
    check("t1_rst_starve", STARVE, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("t1_idle_ram_en", RAM_EN, 0);
    check("t1_idle_state",  CPU_STATE, 0);

    // 2: display only, one request every 2 cycles
    dv_edge.delete(); dv_data.delete();
    k0 = edge_n;
    for (int i = 0; i < 8; i++) begin
      DISP_REQ = 1'b1; DISP_ADDR = AW'(i);
      @(negedge CLK);
      DISP_REQ = 1'b0;
      @(negedge CLK);
    end
    repeat (4) @(negedge CLK);
    check("t2_dv_count", dv_edge.size(), 8);
    for (int i = 0; i < 8 && i < dv_edge.size(); i++) begin
      exp_d = DW'(i) ^ 8'hA5;
      check("t2_dv_latency", dv_edge[i] - (k0 + 2*i), 3);
      check("t2_dv_data",    dv_data[i], exp_d);
    end

    // 3: CPU write then read back
    cpu_start(1'b1, 15'h1234, 8'h3C);
    cpu_wait_ack(lat, rd);
    check("t3_wr_latency", lat, 1);
    @(negedge CLK);
    cpu_start(1'b0, 15'h1234, 8'h00);
    cpu_wait_ack(lat, rd);
    check("t3_rd_latency", lat, 3);
    check("t3_rd_data",    rd, 8'h3C);
    repeat (2) @(negedge CLK);

    // 4: collision, display wins, CPU follows one edge later
    dv_edge.delete(); dv_data.delete();
    k0 = edge_n;
    DISP_REQ = 1'b1; DISP_ADDR = 15'h0020;
    cpu_start(1'b0, 15'h0010, 8'h00);
    cpu_wait_ack(lat, rd);
    check("t4_cpu_latency", lat, 4);
    check("t4_cpu_data",    rd, 8'hB5);
    check("t4_dv_count",    dv_edge.size(), 1);
    if (dv_edge.size() > 0) begin
      check("t4_dv_latency", dv_edge[0] - k0, 3);
      check("t4_dv_data",    dv_data[0], 8'h85);
    end
    repeat (3) @(negedge CLK);

    // 5: starvation by back-to-back display requests
    ack_cnt = 0;
    DISP_REQ = 1'b1; DISP_ADDR = 15'h0005;
    cpu_start(1'b0, 15'h0100, 8'h00);
    repeat (14) @(negedge CLK);
    check("t5_starve_at14", STARVE, 0);
    @(negedge CLK);
    check("t5_starve_at15", STARVE, 1);
    repeat (5) @(negedge CLK);
    check("t5_no_grant", ack_cnt, 0);
    DISP_REQ = 1'b0;
    cpu_wait_ack(lat, rd);
    check("t5_cpu_latency", lat, 3);
    check("t5_cpu_data",    rd, 8'hA5);
    repeat (3) @(negedge CLK);
    check("t5_starve_sticky", STARVE, 1);

    // 6: reset during a CPU read
    a = 15'h0200;
    cpu_start(1'b0, a, 8'h00);
    @(negedge CLK);
    check("t6_in_rd1", CPU_STATE, 2'(CPU_RD1));
    ack_cnt = 0;
    RESET = 1'b1; CPU_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);
    check("t6_no_ack", ack_cnt, 0);
    check("t6_idle",   CPU_STATE, 2'(CPU_IDLE));
    check("t6_starve", STARVE, 0);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
